// File: rtl/mips_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_mdu_pkg
// Brief  : Op encodings, FSM states and op decode helpers for the MDU
// Rev    : 1.0
// ============================================================================
package mips_mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e o);
        return (o == MDU_DIV) || (o == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module : mdu_step
// Brief  : One iteration of shift-add multiply or restoring divide
// Rev    : 1.0
// ============================================================================
module mdu_step #(
    parameter int DATA_W = 32
) (
    input  logic                i_is_div,
    input  logic [2*DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [2*DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0]   o_a,
    output logic [DATA_W-1:0]   o_b
);
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_shifted;
    logic [DATA_W:0] w_trial;

    always_comb begin
        w_sum     = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + (i_b[0] ? {1'b0, i_a} : '0);
        w_shifted = {i_acc[2*DATA_W-1:DATA_W], i_a[DATA_W-1]};
        w_trial   = w_shifted - {1'b0, i_b};
        o_a       = i_a;
        o_b       = i_b;
        if (i_is_div) begin
            // Operands rotate rather than shift so they are intact after DATA_W steps
            o_a = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
            if (!w_trial[DATA_W])
                o_acc = {w_trial[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b1};
            else
                o_acc = {w_shifted[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b0};
        end else begin
            o_b   = {i_b[0], i_b[DATA_W-1:1]};
            o_acc = {w_sum, i_acc[DATA_W-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_mdu.sv
`default_nettype none
// ============================================================================
// Module : mips_mdu
// Brief  : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair
// Rev    : 1.0
// ============================================================================
module mips_mdu
    import mips_mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cancel,
    input  logic              hi_wr,
    input  logic              lo_wr,
    input  logic              hilo_rd,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic              stall_req
);
    localparam int                c_cnt_w     = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    mdu_state_e          state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    mdu_op_e             op_q, op_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic                sign_qp_q, sign_qp_d;
    logic                sign_r_q, sign_r_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;

    logic                w_is_signed;
    logic                w_is_div;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;
    logic [2*DATA_W-1:0] w_step_acc;
    logic [DATA_W-1:0]   w_step_a;
    logic [DATA_W-1:0]   w_step_b;

    assign w_is_signed = op_is_signed(mdu_op_e'(op));
    assign w_is_div    = op_is_div(op_q);
    assign w_abs_a     = (w_is_signed && a[DATA_W-1]) ? -a : a;
    assign w_abs_b     = (w_is_signed && b[DATA_W-1]) ? -b : b;

    // Magnitude results are sign-corrected only once, in FIX
    assign w_prod = sign_qp_q ? -acc_q : acc_q;
    assign w_quo  = sign_qp_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign w_rem  = sign_r_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

    mdu_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_is_div (w_is_div),
        .i_acc    (acc_q),
        .i_a      (opa_q),
        .i_b      (opb_q),
        .o_acc    (w_step_acc),
        .o_a      (w_step_a),
        .o_b      (w_step_b)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        sign_qp_d = sign_qp_q;
        sign_r_d  = sign_r_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    op_d      = mdu_op_e'(op);
                    opa_d     = w_abs_a;
                    opb_d     = w_abs_b;
                    acc_d     = '0;
                    sign_qp_d = w_is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                    sign_r_d  = w_is_signed & a[DATA_W-1];
                    dbz_d     = 1'b0;
                end else begin
                    if (hi_wr) hi_d = a;
                    if (lo_wr) lo_d = a;
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_d = w_step_acc;
                    opa_d = w_step_a;
                    opb_d = w_step_b;
                    cnt_d = cnt_q + c_cnt_one;
                    if (cnt_q == c_last_iter) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!w_is_div) begin
                        {hi_d, lo_d} = w_prod;
                    end else if (opb_q == '0) begin
                        lo_d  = '1;
                        hi_d  = opa_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = w_quo;
                        hi_d = w_rem;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= MDU_MULT;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            sign_qp_q <= 1'b0;
            sign_r_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            sign_qp_q <= sign_qp_d;
            sign_r_q  <= sign_r_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign stall_req   = busy & (start | hilo_rd | hi_wr | lo_wr);

endmodule
`default_nettype wire

// File: doc/mips_mdu.md
# mips_mdu

Parametrised iterative multiply/divide unit for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU, and owns the HI/LO register pair. It sits beside the EX stage, accepts one operation per start pulse, and raises a stall request toward the hazard logic while a result is pending. Operand width is generic, so the same block serves 32-bit and narrower test cores.

## Interface
- DATA_W, 32, operand and HI/LO width; must be even and ≥ 4. The iteration-counter width $clog2(DATA_W) is derived locally.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  issue the operation in `op` using `a`, `b`; honoured only in IDLE
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- a, b  in  DATA_W each  operands; `a` is the multiplicand or dividend
- cancel  in  1  pipeline flush; aborts any pending operation
- hi_wr, lo_wr  in  1 each  MTHI/MTLO write strobes; data taken from `a`
- hilo_rd  in  1  an instruction in D/E reads HI or LO (MFHI/MFLO)
- hi, lo  out  DATA_W each  architectural HI/LO registers
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse; `hi`/`lo` hold the new result in the same cycle
- div_by_zero  out  1  registered; valid while `done` is high
- stall_req  out  1  combinational: busy & (start | hilo_rd | hi_wr | lo_wr)

## Operation
- FSM states and transitions:
  - IDLE → CALC on start & !cancel.
  - CALC runs DATA_W iterations, then moves to FIX.
  - FIX → IDLE, writing HI/LO and pulsing `done`.
- On start:
  - Latch op.
  - Latch |a| and |b| for signed ops, or the raw values for unsigned ops.
  - Latch result signs: product sign = a[MSB]^b[MSB]; quotient sign likewise; remainder sign = a[MSB].
  - Clear the 2·DATA_W accumulator.
- Multiply: shift-add, one multiplier bit per cycle, LSB first. The 2·DATA_W product goes to {HI,LO}, negated in FIX if the product sign is set.
- Divide: restoring, one quotient bit per cycle, MSB first. LO = quotient, HI = remainder, each negated in FIX per its sign.
- Divide by zero (b==0, DIV or DIVU): full latency still applies. FIX forces LO = all ones and HI = a as latched, and sets div_by_zero.
- DIV of the most-negative value by −1: LO = most-negative value, HI = 0. No flag is raised.
- The FSM ignores start while busy; the pipeline must hold the instruction via stall_req.
- cancel:
  - In CALC or FIX, the next edge returns the FSM to IDLE. HI/LO are unchanged and no done pulse occurs.
  - In IDLE, cancel suppresses a coincident start.
- hi_wr/lo_wr:
  - Accepted only in IDLE, with the write visible the next cycle.
  - Ignored if start is accepted in the same cycle.
  - Ignored when busy; stall_req covers this case.
- div_by_zero clears when the next operation is accepted.

## Timing
- Reset (async, rst_n low): state = IDLE; hi, lo = 0; busy, done, div_by_zero = 0. stall_req therefore reads 0.
- Reset mid-operation: immediate abort to the reset values above.
- Start sampled at edge E0 → busy high from E0.
- CALC iterations occupy edges E1..E_DATA_W.
- FIX completes at edge E_DATA_W+1: HI/LO are updated, done = 1, busy = 0.
- Latency from start edge to result is DATA_W+1 edges; 33 for DATA_W = 32.
- A new start is accepted in the same cycle that done is high.
- Back-to-back throughput: one operation per DATA_W+1 cycles.

## Structure
- Shared package `mips_mdu_pkg`:
  - op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU.
  - FSM state typedef: IDLE, CALC, FIX.
- One natural sub-module, `mdu_step`: combinational single-iteration logic (add-shift or trial-subtract-shift) on the accumulator, parametrised by DATA_W. The FSM, counter, sign handling and HI/LO registers stay in `mips_mdu`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done 33 cycles after start; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=−3 (0xFFFFFFFD), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=0 → LO=0xFFFFFFFF, HI=0x00000064, div_by_zero=1 with done. A following DIVU 100/7 → LO=14, HI=2, div_by_zero=0.
- Start DIV, assert cancel on cycle 10 → busy low next cycle, HI/LO keep prior values, no done. A new start the following cycle completes normally.
- While busy, pulse hilo_rd, then hi_wr, then start → stall_req=1 each cycle and the operation is not restarted. In IDLE, hi_wr with a=0x12345678 → hi=0x12345678 next cycle and stall_req=0.
- Deassert rst_n during CALC → busy, done, hi, lo = 0 asynchronously. Release, then MULTU 6×7 → LO=42, HI=0.
